hcu_stall_ctrl: RTL and testbench
=================================

# hcu_stall_ctrl

Hazard and stall controller for the five-stage pipeline. It combines register-hazard detection with multiply/divide (MDU) busy tracking and drives the enable and clear controls of the PC, F/D and D/E pipeline registers. It owns the MDU busy countdown and issues the gated MDU start pulse. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  1  exception/interrupt flush request from CP0
- D_rs, D_rt  in  5 each  source registers of the D-stage instruction
- D_Tuse_rs, D_Tuse_rt  in  2 each  cycles until the D instruction needs rs/rt; 3 = not used
- E_dst, M_dst  in  5 each  destination registers in E and M
- E_Tnew, M_Tnew  in  2 each  cycles until the E/M result is available
- D_uses_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_md_start  in  1  E instruction is mult/multu/div/divu
- E_md_is_div  in  1  qualifies E_md_start: 1 = divide
- HCU_EN_PC  out  1  PC register enable
- HCU_EN_FD  out  1  F/D register enable
- HCU_clr_DE  out  1  D/E register clear (bubble insert)
- md_start  out  1  start pulse to the MDU
- md_busy  out  1  MDU busy (registered state)
- md_cnt  out  4  remaining MDU busy cycles
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Register hazard, per source s in {rs, rt}: haz_s = (D_s != 0) & ((D_s == E_dst & D_Tuse_s < E_Tnew) | (D_s == M_dst & D_Tuse_s < M_Tnew)).
- MDU hazard: haz_md = D_uses_md & (E_md_start | md_busy).
- stall = ~req & (haz_rs | haz_rt | haz_md).
- Outputs are combinational from stall:
  - HCU_EN_PC = ~stall
  - HCU_EN_FD = ~stall
  - HCU_clr_DE = stall
- md_start = E_md_start & ~req & ~md_busy.
- MDU FSM:
  - IDLE: on md_start, load md_cnt with DIV_CYCLES if E_md_is_div, else MULT_CYCLES, and go to BUSY.
  - BUSY: md_cnt decrements by 1 each cycle. When md_cnt reaches 1, the next state is IDLE with md_cnt = 0.
  - md_busy = (state == BUSY).
- E_md_start while BUSY cannot occur legally, because D is stalled. If it does occur, it is ignored: no reload and no md_start.
- req does not cancel a divide or multiply already in progress. The countdown continues to completion.
- stall_cnt increments by 1 on every cycle where stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset (reset = 0, asynchronous): state IDLE, md_cnt = 0, md_busy = 0, stall_cnt = 0. The combinational outputs then follow their inputs, so with idle inputs HCU_EN_PC = 1, HCU_EN_FD = 1, HCU_clr_DE = 0, md_start = 0.
- Deassertion of reset takes effect at the next rising clk edge.
- Start handling: md_start high in cycle t gives md_busy = 1 in cycles t+1 .. t+N, where N is MULT_CYCLES or DIV_CYCLES.
  - md_cnt reads N in cycle t+1 and 1 in cycle t+N.
  - md_busy = 0 in cycle t+N+1; a D-stage mfhi/mflo is released in that cycle.
- A D-stage MDU instruction stalls in cycle t (E_md_start) and in cycles t+1 .. t+N. The stall lasts N+1 cycles in total.
- Register-hazard stall holds for as long as the inequality holds. Tnew decreasing as the producer advances ends the stall; no internal state is involved.
- req = 1 forces all stall outputs inactive in the same cycle (HCU_EN_PC = 1, HCU_EN_FD = 1, HCU_clr_DE = 0) and suppresses md_start. stall_cnt does not increment in that cycle.
- If reset is asserted while BUSY, the block returns to IDLE immediately and md_cnt = 0.

## Test plan
- Reset mid-BUSY: start a divide, assert reset at md_cnt = 4 -> md_busy = 0, md_cnt = 0, stall_cnt = 0 immediately; next start counts the full 10 cycles.
- mult with mflo following: E_md_start = 1, E_md_is_div = 0 at t, D_uses_md = 1 held -> md_start pulse at t only; stall at t .. t+5; HCU_EN_FD = 1 at t+6; stall_cnt = 6.
- div: same sequence with E_md_is_div = 1 -> md_cnt goes 10, 9, …, 1, 0; stall lasts 11 cycles.
- Load-use hazard: D_rs = 5, D_Tuse_rs = 0, E_dst = 5, E_Tnew = 2 -> HCU_clr_DE = 1, HCU_EN_PC = 0. Same stimulus with D_rs = 0 -> no stall.
- req during stall: MDU BUSY with D_uses_md = 1, assert req for 1 cycle -> that cycle HCU_EN_PC = 1, HCU_clr_DE = 0, stall_cnt unchanged; md_cnt keeps decrementing.
- req with E_md_start = 1 in IDLE -> md_start = 0, state stays IDLE.
- Saturation: preload near the limit by forcing 65 540 stall cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hcu_stall_ctrl_if.sv
// Signal bundle between the pipeline control path and the hazard/stall controller.
// The master side is the pipeline (drives hazard inputs), the slave side is the controller.
interface hcu_stall_ctrl_if;
  logic       req;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic [4:0] E_dst;
  logic [4:0] M_dst;
  logic [1:0] E_Tnew;
  logic [1:0] M_Tnew;
  logic       D_uses_md;
  logic       E_md_start;
  logic       E_md_is_div;

  logic        HCU_EN_PC;
  logic        HCU_EN_FD;
  logic        HCU_clr_DE;
  logic        md_start;
  logic        md_busy;
  logic [3:0]  md_cnt;
  logic [15:0] stall_cnt;

  modport master (
    output req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_dst, M_dst, E_Tnew, M_Tnew,
           D_uses_md, E_md_start, E_md_is_div,
    input  HCU_EN_PC, HCU_EN_FD, HCU_clr_DE, md_start, md_busy, md_cnt, stall_cnt
  );

  modport slave (
    input  req, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_dst, M_dst, E_Tnew, M_Tnew,
           D_uses_md, E_md_start, E_md_is_div,
    output HCU_EN_PC, HCU_EN_FD, HCU_clr_DE, md_start, md_busy, md_cnt, stall_cnt
  );
endinterface

// File: rtl/hcu_stall_ctrl.sv
// Hazard/stall controller: register and MDU hazard detection, MDU busy countdown,
// pipeline enable/clear generation and a saturating stall-cycle counter.
module hcu_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  hcu_stall_ctrl_if.slave  bus
);

  localparam logic [3:0]  MultLoad = 4'(MULT_CYCLES);
  localparam logic [3:0]  DivLoad  = 4'(DIV_CYCLES);
  localparam logic [15:0] StallMax = 16'hFFFF;

  typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic haz_rs, haz_rt, haz_md;
  logic stall;
  logic md_busy;
  logic md_start;

  // A source conflicts with a producer when it names the same non-zero register
  // and is needed before the producer's result becomes available.
  function automatic logic src_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] e_dst,
                                      input logic [1:0] e_tnew,
                                      input logic [4:0] m_dst,
                                      input logic [1:0] m_tnew);
    logic e_hit, m_hit;
    e_hit = (src == e_dst) && (tuse < e_tnew);
    m_hit = (src == m_dst) && (tuse < m_tnew);
    return (src != 5'd0) && (e_hit || m_hit);
  endfunction

  assign md_busy = (state_q == StBusy);

  always_comb begin
    haz_rs   = src_hazard(bus.D_rs, bus.D_Tuse_rs, bus.E_dst, bus.E_Tnew,
                          bus.M_dst, bus.M_Tnew);
    haz_rt   = src_hazard(bus.D_rt, bus.D_Tuse_rt, bus.E_dst, bus.E_Tnew,
                          bus.M_dst, bus.M_Tnew);
    haz_md   = bus.D_uses_md && (bus.E_md_start || md_busy);
    stall    = !bus.req && (haz_rs || haz_rt || haz_md);
    md_start = bus.E_md_start && !bus.req && !md_busy;
  end

  // MDU countdown. A start seen while busy is ignored; req never aborts a countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (md_start) begin
          cnt_d   = bus.E_md_is_div ? DivLoad : MultLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != StallMax)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.HCU_EN_PC  = !stall;
  assign bus.HCU_EN_FD  = !stall;
  assign bus.HCU_clr_DE = stall;
  assign bus.md_start   = md_start;
  assign bus.md_busy    = md_busy;
  assign bus.md_cnt     = cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hcu_stall_ctrl.sv
// Randomised and directed bench for hcu_stall_ctrl with a cycle-stamped reference
// model; expectations are queued by the driver and checked by a negedge monitor.
module tb_hcu_stall_ctrl;

  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  logic clk;
  logic reset;

  hcu_stall_ctrl_if bus ();

  hcu_stall_ctrl #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic       rst;
    logic       req;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] e_dst;
    logic [4:0] m_dst;
    logic [1:0] e_tnew;
    logic [1:0] m_tnew;
    logic       uses_md;
    logic       md_start;
    logic       is_div;
  } stim_t;

  typedef struct {
    longint cyc;
    logic   en_pc;
    logic   en_fd;
    logic   clr;
    logic   start;
    logic   busy;
    int     cnt;
    int     scnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: the MDU is busy for cycles strictly before m_end.
  longint m_cyc  = 0;
  longint m_end  = 0;
  int     m_scnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint cyc, input longint act,
                       input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0;  s.req = 1'b0;
    s.rs = '0;     s.rt = '0;
    s.tuse_rs = 2'd3; s.tuse_rt = 2'd3;
    s.e_dst = '0;  s.m_dst = '0;
    s.e_tnew = '0; s.m_tnew = '0;
    s.uses_md = 1'b0; s.md_start = 1'b0; s.is_div = 1'b0;
    return s;
  endfunction

  function automatic bit reg_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                    input stim_t s);
    return (src != 0) && ((src == s.e_dst && tuse < s.e_tnew) ||
                          (src == s.m_dst && tuse < s.m_tnew));
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit   busy, stall, start;
    reset           = ~s.rst;
    bus.req         = s.req;
    bus.D_rs        = s.rs;
    bus.D_rt        = s.rt;
    bus.D_Tuse_rs   = s.tuse_rs;
    bus.D_Tuse_rt   = s.tuse_rt;
    bus.E_dst       = s.e_dst;
    bus.M_dst       = s.m_dst;
    bus.E_Tnew      = s.e_tnew;
    bus.M_Tnew      = s.m_tnew;
    bus.D_uses_md   = s.uses_md;
    bus.E_md_start  = s.md_start;
    bus.E_md_is_div = s.is_div;
    if (s.rst) begin
      m_end  = m_cyc;
      m_scnt = 0;
    end
    busy  = m_cyc < m_end;
    stall = !s.req && (reg_hazard(s.rs, s.tuse_rs, s) || reg_hazard(s.rt, s.tuse_rt, s) ||
                       (s.uses_md && (s.md_start || busy)));
    start = s.md_start && !s.req && !busy;
    e.cyc   = m_cyc;
    e.en_pc = !stall;
    e.en_fd = !stall;
    e.clr   = stall;
    e.start = start;
    e.busy  = busy;
    e.cnt   = busy ? int'(m_end - m_cyc) : 0;
    e.scnt  = m_scnt;
    exp_q.push_back(e);
    if (s.rst) begin
      @(negedge clk);
      #1 reset = 1'b1;
    end
    @(posedge clk);
    if (start) m_end = m_cyc + 1 + (s.is_div ? DivCycles : MultCycles);
    if (stall && m_scnt < 'hFFFF) m_scnt++;
    m_cyc++;
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("HCU_EN_PC",  mon_e.cyc, longint'(bus.HCU_EN_PC),  longint'(mon_e.en_pc));
      check("HCU_EN_FD",  mon_e.cyc, longint'(bus.HCU_EN_FD),  longint'(mon_e.en_fd));
      check("HCU_clr_DE", mon_e.cyc, longint'(bus.HCU_clr_DE), longint'(mon_e.clr));
      check("md_start",   mon_e.cyc, longint'(bus.md_start),   longint'(mon_e.start));
      check("md_busy",    mon_e.cyc, longint'(bus.md_busy),    longint'(mon_e.busy));
      check("md_cnt",     mon_e.cyc, longint'(bus.md_cnt),     longint'(mon_e.cnt));
      check("stall_cnt",  mon_e.cyc, longint'(bus.stall_cnt),  longint'(mon_e.scnt));
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    s = idle();
    bus.req = 1'b0; bus.D_rs = '0; bus.D_rt = '0; bus.D_Tuse_rs = 2'd3; bus.D_Tuse_rt = 2'd3;
    bus.E_dst = '0; bus.M_dst = '0; bus.E_Tnew = '0; bus.M_Tnew = '0;
    bus.D_uses_md = 1'b0; bus.E_md_start = 1'b0; bus.E_md_is_div = 1'b0;
    @(posedge clk);
    #1;
    s = idle(); s.rst = 1'b1;
    step(s);
    step(idle());

    // Reset while a divide is counting down, then a fresh full-length divide.
    s = idle(); s.md_start = 1'b1; s.is_div = 1'b1;
    step(s);
    for (int i = 0; i < 20 && (m_end - m_cyc) != 4; i++) step(idle());
    s = idle(); s.rst = 1'b1; s.uses_md = 1'b1;
    step(s);
    s = idle(); s.md_start = 1'b1; s.is_div = 1'b1;
    step(s);
    for (int i = 0; i < 12; i++) step(idle());

    // mult then div, each followed by an MDU consumer held in D.
    for (int d = 0; d < 2; d++) begin
      s = idle(); s.md_start = 1'b1; s.is_div = d[0]; s.uses_md = 1'b1;
      step(s);
      s = idle(); s.uses_md = 1'b1;
      for (int i = 0; i < 13; i++) step(s);
      step(idle());
    end

    // Load-use on rs via E, on rt via M, and the zero-register exemption.
    s = idle(); s.rs = 5'd5; s.tuse_rs = 2'd0; s.e_dst = 5'd5; s.e_tnew = 2'd2;
    step(s);
    s.rs = 5'd0;
    step(s);
    s = idle(); s.rt = 5'd7; s.tuse_rt = 2'd1; s.m_dst = 5'd7; s.m_tnew = 2'd2;
    step(s);
    s.m_tnew = 2'd1;
    step(s);

    // req during an MDU stall: stall suppressed, countdown continues.
    s = idle(); s.md_start = 1'b1; s.is_div = 1'b1; s.uses_md = 1'b1;
    step(s);
    s = idle(); s.uses_md = 1'b1;
    step(s); step(s);
    s.req = 1'b1;
    step(s);
    s.req = 1'b0;
    for (int i = 0; i < 10; i++) step(s);

    // req with a start request while idle: no start, stays idle.
    step(idle());
    s = idle(); s.md_start = 1'b1; s.req = 1'b1; s.uses_md = 1'b1;
    step(s);
    step(idle()); step(idle());

    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst      = ($urandom_range(0, 79) == 0);
      s.req      = ($urandom_range(0, 7) == 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.tuse_rs  = 2'($urandom_range(0, 3));
      s.tuse_rt  = 2'($urandom_range(0, 3));
      s.e_dst    = 5'($urandom_range(0, 3));
      s.m_dst    = 5'($urandom_range(0, 3));
      s.e_tnew   = 2'($urandom_range(0, 3));
      s.m_tnew   = 2'($urandom_range(0, 3));
      s.uses_md  = 1'($urandom_range(0, 1));
      s.md_start = ($urandom_range(0, 3) == 0);
      s.is_div   = 1'($urandom_range(0, 1));
      step(s);
    end

    // Saturation of the stall counter.
    s = idle(); s.rs = 5'd1; s.tuse_rs = 2'd0; s.e_dst = 5'd1; s.e_tnew = 2'd1;
    for (int i = 0; i < 65540; i++) step(s);
    step(s);
    step(idle());

    check("scoreboard_drain", m_cyc, longint'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
